// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder in front of a word-organised flop memory.
// It handles one outstanding transfer with pipelined address and data phases.
// It inserts WAIT_CYCLES wait states per data phase and drives byte lanes from HSIZE/HADDR.
// Optional macro AHB_SLV_ERRRESP_EN: when defined, a bad transfer gets a two-cycle
// ERROR response. Otherwise it completes as a normal OKAY data phase with no effect.
module ahb_sram_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int NUM_LANES = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
`ifdef AHB_SLV_ERRRESP_EN
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;
`endif

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [1:0]             accept_state;
  logic [2:0]             wait_cnt;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_LANES-1:0]   strb_q;
  logic                   write_q;
  logic                   bad_q;
  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  logic [ADDR_WIDTH:0]    addr_diff;
  logic [ADDR_WIDTH-1:0]  word_idx;
  logic [IDX_W-1:0]       acc_idx;
  logic                   acc_bad;
  logic [NUM_LANES-1:0]   acc_strb;
  logic                   slave_ready;
  logic                   take;
  logic                   commit;
  logic [DATA_WIDTH-1:0]  rd_word;
  logic                   unused_inputs;

  // The burst, protection and lock qualifiers carry no meaning for a plain memory
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

  // The borrow of the extended subtraction flags addresses below the window
  assign addr_diff = {1'b0, HADDR} - {1'b0, BASE_ADDR};
  assign word_idx  = addr_diff[ADDR_WIDTH-1:0] >> 2;
  assign acc_idx   = word_idx[IDX_W-1:0];
  assign acc_bad   = addr_diff[ADDR_WIDTH]
                   || (word_idx >= ADDR_WIDTH'(MEM_DEPTH))
                   || (HSIZE > 3'd2)
                   || ((HSIZE == 3'd1) && HADDR[0])
                   || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

  // Byte-lane strobes for the transfer in its address phase
  always_comb begin
    case (HSIZE)
      3'd0:    acc_strb = 4'b0001 << HADDR[1:0];
      3'd1:    acc_strb = 4'b0011 << HADDR[1:0];
      default: acc_strb = 4'b1111;
    endcase
  end

  // The slave is ready when idle, on the last data cycle, and on the second error cycle
  always_comb begin
    slave_ready = 1'b1;
    case (state)
      ST_DATA: slave_ready = (wait_cnt == 3'd0);
`ifdef AHB_SLV_ERRRESP_EN
      ST_ERR1: slave_ready = 1'b0;
`endif
      default: slave_ready = 1'b1;
    endcase
  end

  assign HREADYOUT = slave_ready;
`ifdef AHB_SLV_ERRRESP_EN
  assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
`else
  assign HRESP     = 1'b0;
`endif

  assign take   = HSEL && HREADY && HTRANS[1] && slave_ready;
  assign commit = (state == ST_DATA) && (wait_cnt == 3'd0) && write_q && !bad_q;

  // Read data, with a bypass of the write that commits on the same edge
  always_comb begin
    rd_word = mem[acc_idx];
    for (int i = 0; i < NUM_LANES; i++) begin
      if (commit && (idx_q == acc_idx) && strb_q[i]) begin
        rd_word[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  // Next state: a new transfer is considered only in cycles where the slave is ready
  always_comb begin
    accept_state = ST_IDLE;
    if (take) begin
`ifdef AHB_SLV_ERRRESP_EN
      accept_state = acc_bad ? ST_ERR1 : ST_DATA;
`else
      accept_state = ST_DATA;
`endif
    end
    state_nxt = state;
    case (state)
      ST_DATA: state_nxt = (wait_cnt != 3'd0) ? ST_DATA : accept_state;
`ifdef AHB_SLV_ERRRESP_EN
      ST_ERR1: state_nxt = ST_ERR2;
`endif
      default: state_nxt = accept_state;
    endcase
  end

  // Control state, latched transfer attributes, wait counter and registered read data
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
      idx_q    <= '0;
      strb_q   <= '0;
      write_q  <= 1'b0;
      bad_q    <= 1'b0;
      HRDATA   <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        wait_cnt <= 3'(WAIT_CYCLES);
        idx_q    <= acc_idx;
        strb_q   <= acc_strb;
        write_q  <= HWRITE;
        bad_q    <= acc_bad;
        if (!HWRITE) begin
          HRDATA <= acc_bad ? '0 : rd_word;
        end
      end else if ((state == ST_DATA) && (wait_cnt != 3'd0)) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
    end
  end

  // Write data lands on the strobed byte lanes in the final data-phase cycle
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (strb_q[i]) begin
          mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: bench for ahb_sram_slave.
// Two instances, one zero-wait and one with three wait states, sit on a shared bus.
// A target select steers the bus to one of them.
// The expected responses come from a byte-level memory model and are queued as each
// transfer is issued. A monitor pops them as each data phase completes.
// The optional error response (AHB_SLV_ERRRESP_EN) changes the expected timing.
module tb_ahb_sram_slave;

  localparam int DEPTH     = 16;
  localparam int SLOW_WAIT = 3;

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    int          waits;
    bit          resp;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        bus_sel;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        target;
  logic        hsel_fast, hsel_slow;
  logic        ready_fast, ready_slow, resp_fast, resp_slow;
  logic [31:0] rdata_fast, rdata_slow;
  logic        cur_ready, cur_resp;
  logic [31:0] cur_rdata;

  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  exp_t        sb[$];
  logic [31:0] model_mem [2][DEPTH];

  always #5 HCLK = ~HCLK;

  assign hsel_fast = bus_sel && !target;
  assign hsel_slow = bus_sel && target;
  assign cur_ready = target ? ready_slow : ready_fast;
  assign cur_resp  = target ? resp_slow : resp_fast;
  assign cur_rdata = target ? rdata_slow : rdata_fast;

  ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
                   .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_fast (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_fast), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'd0),
    .HPROT(4'd0), .HMASTLOCK(1'b0), .HWDATA(HWDATA), .HREADY(ready_fast),
    .HREADYOUT(ready_fast), .HRESP(resp_fast), .HRDATA(rdata_fast));

  ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
                   .BASE_ADDR(32'h0), .WAIT_CYCLES(SLOW_WAIT)) u_slow (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_slow), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'd0),
    .HPROT(4'd0), .HMASTLOCK(1'b0), .HWDATA(HWDATA), .HREADY(ready_slow),
    .HREADYOUT(ready_slow), .HRESP(resp_slow), .HRDATA(rdata_slow));

  // Compare one observed value with its expected value and count the outcome
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic finishRun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // A transfer is bad if it falls outside the window, is too wide, or is misaligned
  function automatic bit isBad(input logic [2:0] size, input logic [31:0] addr);
    int nbytes;
    if (size > 3'd2) return 1'b1;
    nbytes = 1 << size;
    if ((addr % nbytes) != 0) return 1'b1;
    return addr >= 32'(DEPTH * 4);
  endfunction

  // Drive one address phase and queue its expected response; return once it is accepted
  task automatic applyStimulus(input bit sel, input logic [1:0] trans, input bit wr,
                               input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
    exp_t e;
    int   n = 0;
    bit   r;
    int   widx;
    int   lane;
    bus_sel = sel;
    HTRANS  = trans;
    HWRITE  = wr;
    HSIZE   = size;
    HADDR   = addr;
    if (sel && trans[1]) begin
      e.is_read = !wr;
      e.rdata   = 32'h0;
      e.resp    = 1'b0;
      e.waits   = target ? SLOW_WAIT : 0;
      if (isBad(size, addr)) begin
`ifdef AHB_SLV_ERRRESP_EN
        e.waits = 1;
        e.resp  = 1'b1;
`endif
      end else begin
        widx = int'(addr >> 2);
        if (wr) begin
          for (int b = 0; b < (1 << size); b++) begin
            lane = int'(addr[1:0]) + b;
            model_mem[target][widx][8*lane +: 8] = wdata[8*lane +: 8];
          end
        end else begin
          e.rdata = model_mem[target][widx];
        end
      end
      sb.push_back(e);
    end
    do begin
      @(negedge HCLK);
      r = cur_ready;
      @(posedge HCLK);
      #1;
      n++;
      if (n > 20) begin
        errors++;
        $display("[TB] FAIL handshake_timeout: ready low for %0d cycles, required at most 20", n);
        finishRun();
      end
    end while (!r);
    HWDATA = wdata;
  endtask

  // Monitor: follow data phases on the selected target and score each completion
  initial begin : monitor
    bit   dp;
    int   lows;
    exp_t e;
    dp   = 1'b0;
    lows = 0;
    forever begin
      @(negedge HCLK);
      if (!mon_en) begin
        dp   = 1'b0;
        lows = 0;
      end else begin
        if (dp) begin
          if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL scoreboard_underflow: data phase seen with 0 expected entries, required 1");
            dp = 1'b0;
          end else begin
            e = sb[0];
            if (!cur_ready) begin
              lows++;
              checkOutput("wait_resp", {31'h0, cur_resp}, {31'h0, e.resp});
            end else begin
              void'(sb.pop_front());
              checkOutput("wait_count", lows, e.waits);
              checkOutput("resp", {31'h0, cur_resp}, {31'h0, e.resp});
              if (e.is_read) checkOutput("rdata", cur_rdata, e.rdata);
              lows = 0;
            end
          end
        end else begin
          checkOutput("idle_ready", {31'h0, cur_ready}, 32'h1);
          checkOutput("idle_resp", {31'h0, cur_resp}, 32'h0);
        end
        if (cur_ready) dp = bus_sel && HTRANS[1];
      end
    end
  end

  // One full pass against the target currently selected
  task automatic runPhase(input bit t);
    logic [2:0]  size;
    logic [31:0] addr;
    logic [1:0]  trans;
    int          r;
    target = t;
    applyStimulus(1'b1, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 3'd2, 32'h4, 32'h0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 2'b10, 1'b1, 3'd2, 32'(i * 4), $urandom);
    applyStimulus(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b1, 3'd0, 32'h11, 32'h0000AA00);
    applyStimulus(1'b1, 2'b10, 1'b1, 3'd1, 32'h12, 32'h12340000);
    applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 32'h55667788);
    applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, 32'h02, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b1, 3'd2, 32'h40, 32'h11111111);
    applyStimulus(1'b1, 2'b10, 1'b1, 3'd2, 32'h02, 32'h22222222);
    applyStimulus(1'b1, 2'b10, 1'b1, 3'd3, 32'h04, 32'h33333333);
    applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, 32'h00, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, 32'h04, 32'h0);
    for (int i = 0; i < 150; i++) begin
      r     = $urandom_range(0, 7);
      trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : ((r % 2) == 0) ? 2'b10 : 2'b11;
      r     = $urandom_range(0, 4);
      size  = (r == 4) ? 3'd3 : (r == 3) ? 3'd2 : 3'(r);
      addr  = 32'($urandom_range(0, 32'h47));
      if (($urandom_range(0, 3) != 0) && (size <= 3'd2)) addr = addr & ~((32'h1 << size) - 32'h1);
      applyStimulus($urandom_range(0, 7) != 0, trans, 1'($urandom_range(0, 1)), size, addr, $urandom);
    end
    applyStimulus(1'b1, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
  endtask

  // Main sequence: reset, both targets, then a reset during a wait-stated write
  initial begin : stimulus
    HRESETn = 1'b0;
    bus_sel = 1'b0;
    HADDR   = 32'h0;
    HTRANS  = 2'b00;
    HWRITE  = 1'b0;
    HSIZE   = 3'd2;
    HWDATA  = 32'h0;
    target  = 1'b0;
    #12;
    checkOutput("reset_ready_fast", {31'h0, ready_fast}, 32'h1);
    checkOutput("reset_resp_fast", {31'h0, resp_fast}, 32'h0);
    checkOutput("reset_rdata_fast", rdata_fast, 32'h0);
    checkOutput("reset_ready_slow", {31'h0, ready_slow}, 32'h1);
    checkOutput("reset_resp_slow", {31'h0, resp_slow}, 32'h0);
    checkOutput("reset_rdata_slow", rdata_slow, 32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    mon_en  = 1'b1;
    runPhase(1'b0);
    runPhase(1'b1);

    mon_en  = 1'b0;
    bus_sel = 1'b1;
    HADDR   = 32'h8;
    HTRANS  = 2'b10;
    HWRITE  = 1'b1;
    HSIZE   = 3'd2;
    @(posedge HCLK);
    #1;
    HTRANS = 2'b00;
    HWDATA = 32'hCAFEF00D;
    checkOutput("mid_wait_ready", {31'h0, ready_slow}, 32'h0);
    @(posedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("async_reset_ready", {31'h0, ready_slow}, 32'h1);
    checkOutput("async_reset_resp", {31'h0, resp_slow}, 32'h0);
    checkOutput("async_reset_rdata", rdata_slow, 32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    mon_en = 1'b1;
    applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, 32'h8, 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    repeat (3) @(posedge HCLK);
    checkOutput("scoreboard_empty", sb.size(), 32'h0);
    finishRun();
  end

  // Watchdog so the run always ends
  initial begin : watchdog
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    finishRun();
  end

endmodule
